// File: rtl/header_builder.sv
// Streams fixed-format Ethernet/IPv4/UDP frames on AXI-Stream, one per descriptor.
// The header is built from parameters, the clamped length, the flow id and a running ident.
module header_builder #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter logic [47:0] DST_MAC    = 48'h02_00_00_00_00_02,
   parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
   parameter logic [31:0] SRC_IP     = 32'h0A000001,
   parameter logic [31:0] DST_IP     = 32'h0A000002,
   parameter logic [15:0] DST_PORT   = 16'd5000,
   parameter int unsigned MIN_LEN    = 64,
   parameter int unsigned MAX_LEN    = 1514
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_desc_valid,
   output logic                  s_desc_ready,
   input  logic [15:0]           s_desc_pk_len,
   input  logic [7:0]            s_desc_flow_id,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [31:0]           pkt_count
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   localparam logic [KEEP_WIDTH-1:0] KeepOne = KEEP_WIDTH'(1);

   state_e      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  flow_q, flow_d;
   logic [15:0] beat_q, beat_d;
   logic [15:0] ident_q, ident_d;
   logic [31:0] pkt_count_q, pkt_count_d;
   logic        ready_en_q;

   logic         desc_fire;
   logic         last_beat;
   logic [31:0]  beat_base;
   logic [31:0]  last_rem;
   logic [31:0]  byte_idx;
   logic [15:0]  clamped_len;
   logic [335:0] hdr;

   always_comb begin
      if ({16'd0, s_desc_pk_len} < MIN_LEN) begin
         clamped_len = 16'(MIN_LEN);
      end else if ({16'd0, s_desc_pk_len} > MAX_LEN) begin
         clamped_len = 16'(MAX_LEN);
      end else begin
         clamped_len = s_desc_pk_len;
      end
   end

   // Bytes 0..41 in wire order, MSB first
   assign hdr = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, len_q - 16'd14, ident_q,
                 16'h4000, 8'h40, 8'h11, 16'h0000, SRC_IP, DST_IP, 8'h00, flow_q,
                 DST_PORT, len_q - 16'd34, 16'h0000};

   assign beat_base = 32'(beat_q) * KEEP_WIDTH;
   assign last_beat = (beat_base + KEEP_WIDTH) >= {16'd0, len_q};
   assign last_rem  = {16'd0, len_q} - beat_base;

   assign desc_fire     = s_desc_valid && s_desc_ready;
   assign s_desc_ready  = ready_en_q && (state_q == StIdle);
   assign m_axis_tvalid = (state_q == StSend);
   assign m_axis_tlast  = (state_q == StSend) && last_beat;
   assign pkt_count     = pkt_count_q;

   always_comb begin
      m_axis_tdata = '0;
      m_axis_tkeep = '0;
      byte_idx     = '0;
      if (state_q == StSend) begin
         for (int k = 0; k < int'(KEEP_WIDTH); k++) begin
            byte_idx = beat_base + 32'(k);
            // Lanes past the frame end stay zero with tkeep clear
            if (!last_beat || (32'(k) < last_rem)) begin
               m_axis_tkeep = m_axis_tkeep | (KeepOne << k);
               if (byte_idx < 32'd42) begin
                  m_axis_tdata = m_axis_tdata |
                     (DATA_WIDTH'(8'(hdr >> (8 * (32'd41 - byte_idx)))) << (8 * k));
               end else begin
                  m_axis_tdata = m_axis_tdata | (DATA_WIDTH'(byte_idx[7:0]) << (8 * k));
               end
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      flow_d      = flow_q;
      beat_d      = beat_q;
      ident_d     = ident_q;
      pkt_count_d = pkt_count_q;
      unique case (state_q)
         StIdle: begin
            if (desc_fire) begin
               len_d   = clamped_len;
               flow_d  = s_desc_flow_id;
               beat_d  = '0;
               state_d = StSend;
            end
         end
         StSend: begin
            if (m_axis_tready) begin
               if (last_beat) begin
                  state_d     = StIdle;
                  ident_d     = ident_q + 16'd1;
                  pkt_count_d = pkt_count_q + 32'd1;
               end else begin
                  beat_d = beat_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         len_q       <= '0;
         flow_q      <= '0;
         beat_q      <= '0;
         ident_q     <= '0;
         pkt_count_q <= '0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         flow_q      <= flow_d;
         beat_q      <= beat_d;
         ident_q     <= ident_d;
         pkt_count_q <= pkt_count_d;
         ready_en_q  <= 1'b1;
      end
   end

endmodule
